stepper_phase_ctrl: RTL and testbench
=====================================

# stepper_phase_ctrl

Command-driven sequencer for a Johnson-coded phase generator. It accepts a move command (step count, step period, direction) and advances a WIDTH-bit Johnson phase register one code per step, forward or reverse, at the programmed rate. It reports progress through busy, step and done signals. It sits between a host/control FSM and phase-driven loads such as stepper coil drivers or multiphase clock enables. The phase position is held between commands.

## Interface
- WIDTH, 4: Johnson phase width; the ring has 2*WIDTH states.
- CNT_W, 16: step-count width.
- DIV_W, 16: step-period width, in clk cycles.

- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous assert, active-low. Released synchronously by the integrator.
- start  in  1  command strobe; sampled only in IDLE.
- dir  in  1  direction: 0 forward, 1 reverse. Latched at start.
- steps  in  CNT_W  number of steps to take. Latched at start.
- period  in  DIV_W  cycles per step; 0 is treated as 1. Latched at start.
- abort  in  1  terminates the move; sampled only in RUN.
- phase  out  WIDTH  current Johnson code. Registered.
- step_pulse  out  1  one-cycle pulse in the cycle a new phase first appears.
- busy  out  1  high while the FSM is in RUN.
- done  out  1  one-cycle pulse at the end of a move, on completion, abort or a zero-step command.
- steps_left  out  CNT_W  remaining steps. Registered.

## Operation
- Reset values (rst=0): phase=0, step_pulse=0, busy=0, done=0, steps_left=0, state=IDLE, divider=0.
- Forward step: phase <= {phase[WIDTH-2:0], ~phase[WIDTH-1]}. For WIDTH=4 the sequence is 0000→0001→0011→0111→1111→1110→1100→1000→0000.
- Reverse step: phase <= {~phase[0], phase[WIDTH-1:1]}. This is the exact inverse of a forward step.
- Illegal phase (not one of the 2*WIDTH Johnson codes): the next step loads 0 regardless of dir.
- The FSM has three states: IDLE, RUN, FINISH.
- IDLE, on start with steps≠0:
  - latch dir, steps and max(period,1);
  - divider <= max(period,1)-1;
  - steps_left <= steps;
  - next state RUN.
- IDLE, on start with steps=0: next state FINISH; no step occurs. abort is ignored in IDLE.
- RUN, each cycle:
  - if abort: go to FINISH. No step, even if divider=0. phase and steps_left are held.
  - else if divider=0: step phase, step_pulse <= 1, steps_left <= steps_left-1, divider <= period_l-1. If steps_left was 1, go to FINISH.
  - else: divider <= divider-1.
- start is ignored in RUN and FINISH; no queuing.
- FINISH: done=1 for exactly one cycle, then IDLE. busy=0 in FINISH.
- Arithmetic: the divider and steps_left are unsigned. steps_left never underflows, because FINISH is entered at its 1→0 transition.

## Timing
- start accepted at cycle T: busy is high from T+1.
- Step k (1..N) asserts step_pulse in cycle T+k*period+1. The new phase is visible in that same cycle.
- Steps are spaced exactly period cycles apart; with period=1, step_pulse is continuous.
- Completion: done is high in cycle T+N*period+1, coincident with the last step_pulse. busy is low in that cycle. A new start is accepted from T+N*period+2.
- Zero-step command: done at T+1; busy never asserts.
- abort sampled in cycle A: done at A+1, busy low at A+1, no step_pulse at A+1.
- Reset asserted mid-move: all outputs take their reset values immediately, without waiting for a clock edge.

## Structure
- Shared package stepper_pkg holds the state encoding (IDLE=2'd0, RUN=2'd1, FINISH=2'd2) and the direction constants DIR_FWD=1'b0 and DIR_REV=1'b1.
- Sub-module johnson_phase_gen (WIDTH): a phase register with step-enable, dir and illegal-code recovery. It uses the same clk and rst.
- The top level holds the FSM, divider, step counter and output registers.

## Test plan
- Reset: drive rst=0 mid-simulation. phase=0000, busy=0, done=0, step_pulse=0 and steps_left=0 take effect immediately and hold until rst=1.
- Forward move: start at T with steps=8, period=3, dir=0. Expect 8 step_pulses at T+4, T+7, …, T+25, with phase 0001,0011,0111,1111,1110,1100,1000,0000. done=1 only at T+25. busy high T+1..T+24.
- Reverse move: steps=3, period=1, dir=1, starting from phase 0000. Expect phase 1000, 1100, 1110 in three consecutive cycles T+2..T+4. Reissue the same command with dir=0 and confirm phase returns to 0000.
- Abort: steps=5, period=2, with abort pulsed the cycle after the 2nd step_pulse. Expect done next cycle, steps_left=3, phase frozen at the 2nd code, and no further step_pulse.
- Zero steps: start with steps=0 gives done at T+1 with busy never high. start pulsed while busy is ignored: the step count and completion cycle are unchanged.
- Period 0 and reset mid-move: period=0, steps=4 behaves as period=1. Asserting rst=0 after 2 steps clears all outputs; a fresh command then starts from phase 0000.

Source files
------------

// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper phase sequencer: FSM state encoding and
// direction constants.
`timescale 1ns/1ps
package stepper_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/johnson_phase_gen.sv
// Johnson-coded phase register: advances one code per enabled step in either
// direction and falls back to the all-zero code from any illegal pattern.
`timescale 1ns/1ps
module johnson_phase_gen
    import stepper_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_step,
    input  logic             i_dir,
    output logic [WIDTH-1:0] o_phase
);

    logic [WIDTH-1:0] r_phase;
    logic [WIDTH-2:0] w_edges;
    logic             w_legal;

    // A legal Johnson code is a thermometer pattern: at most one bit boundary
    // where neighbouring bits differ.
    assign w_edges = r_phase[WIDTH-1:1] ^ r_phase[WIDTH-2:0];
    assign w_legal = ((w_edges & (w_edges - (WIDTH-1)'(1))) == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase <= '0;
        end else if (i_step) begin
            if (!w_legal) begin
                r_phase <= '0;
            end else if (i_dir == DIR_REV) begin
                r_phase <= {~r_phase[0], r_phase[WIDTH-1:1]};
            end else begin
                r_phase <= {r_phase[WIDTH-2:0], ~r_phase[WIDTH-1]};
            end
        end
    end

    assign o_phase = r_phase;

endmodule

// File: rtl/stepper_phase_ctrl.sv
// Command-driven move sequencer: latches a step count, period and direction,
// then steps the Johnson phase generator at that rate and reports progress.
`timescale 1ns/1ps
module stepper_phase_ctrl
    import stepper_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] steps,
    input  logic [DIV_W-1:0] period,
    input  logic             abort,
    output logic [WIDTH-1:0] phase,
    output logic             step_pulse,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] steps_left
);

    state_t           r_state;
    logic             r_dir;
    logic [DIV_W-1:0] r_period_l;
    logic [DIV_W-1:0] r_divider;
    logic [CNT_W-1:0] r_steps_left;
    logic             r_step_pulse;
    logic             r_busy;
    logic             r_done;

    logic [DIV_W-1:0] w_period_eff;
    logic             w_step;

    assign w_period_eff = (period == '0) ? DIV_W'(1) : period;
    // Shared with the phase register so the new code lands on the same edge
    // that raises step_pulse.
    assign w_step = (r_state == RUN) && !abort && (r_divider == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_dir        <= DIR_FWD;
            r_period_l   <= '0;
            r_divider    <= '0;
            r_steps_left <= '0;
            r_step_pulse <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_step_pulse <= 1'b0;
            r_done       <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (steps != '0) begin
                            r_dir        <= dir;
                            r_period_l   <= w_period_eff;
                            r_divider    <= w_period_eff - DIV_W'(1);
                            r_steps_left <= steps;
                            r_busy       <= 1'b1;
                            r_state      <= RUN;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= FINISH;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= FINISH;
                    end else if (r_divider == '0) begin
                        r_step_pulse <= 1'b1;
                        r_steps_left <= r_steps_left - CNT_W'(1);
                        r_divider    <= r_period_l - DIV_W'(1);
                        if (r_steps_left == CNT_W'(1)) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= FINISH;
                        end
                    end else begin
                        r_divider <= r_divider - DIV_W'(1);
                    end
                end
                FINISH: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    johnson_phase_gen #(
        .WIDTH(WIDTH)
    ) u_phase_gen (
        .clk    (clk),
        .rst    (rst),
        .i_step (w_step),
        .i_dir  (r_dir),
        .o_phase(phase)
    );

    assign step_pulse = r_step_pulse;
    assign busy       = r_busy;
    assign done       = r_done;
    assign steps_left = r_steps_left;

endmodule

// File: tb/tb_stepper_phase_ctrl.sv
// Self-checking bench for stepper_phase_ctrl: a cycle-timeline model of each
// move checked every cycle, plus directed literal expectations.
`timescale 1ns/1ps
module tb_stepper_phase_ctrl;

    localparam int W  = 4;
    localparam int CW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          dir = 1'b0;
    logic [CW-1:0] steps = '0;
    logic [DW-1:0] period = '0;
    logic          abort = 1'b0;
    logic [W-1:0]  phase;
    logic          step_pulse;
    logic          busy;
    logic          done;
    logic [CW-1:0] steps_left;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model of the current/last move, expressed as a timeline from its start.
    int m_T     = -100;
    int m_N     = 0;
    int m_p     = 1;
    int m_pos0  = 0;
    int m_dsign = 1;
    int m_A     = -1;
    int m_done  = -100;
    int m_sl0   = 0;

    stepper_phase_ctrl #(
        .WIDTH(W),
        .CNT_W(CW),
        .DIV_W(DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dir       (dir),
        .steps     (steps),
        .period    (period),
        .abort     (abort),
        .phase     (phase),
        .step_pulse(step_pulse),
        .busy      (busy),
        .done      (done),
        .steps_left(steps_left)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Ring position i of the 2W-state Johnson sequence starting at all-zero.
    function automatic logic [W-1:0] code(input int i);
        int v;
        if (i <= W) v = (1 << i) - 1;
        else        v = ((1 << W) - 1) & ~((1 << (i - W)) - 1);
        return W'(v);
    endfunction

    function automatic int mk(input int c);
        int cc;
        int q;
        if (m_N == 0) return 0;
        cc = c;
        if (m_A >= 0 && cc > m_A) cc = m_A;
        if (cc < m_T + 1) return 0;
        q = (cc - m_T - 1) / m_p;
        return (q > m_N) ? m_N : q;
    endfunction

    function automatic int mpos(input int c);
        int r;
        r = (m_pos0 + m_dsign * mk(c)) % (2 * W);
        if (r < 0) r += 2 * W;
        return r;
    endfunction

    function automatic int msl(input int c);
        return (m_N == 0) ? m_sl0 : (m_N - mk(c));
    endfunction

    always @(negedge rst) begin
        m_T = -100; m_N = 0; m_p = 1; m_pos0 = 0; m_dsign = 1;
        m_A = -1; m_done = -100; m_sl0 = 0;
    end

    always @(posedge clk) begin : model_step
        int pe;
        int pos_now;
        int sl_now;
        if (rst) begin
            if (m_N > 0 && m_A < 0 && cyc >= m_T + 1 && cyc < m_done && abort) begin
                m_A    = cyc;
                m_done = cyc + 1;
            end else if (start && cyc > m_done) begin
                pos_now = mpos(cyc);
                sl_now  = msl(cyc);
                pe      = (period == 0) ? 1 : int'(period);
                m_pos0  = pos_now;
                m_sl0   = sl_now;
                m_T     = cyc;
                m_N     = int'(steps);
                m_p     = pe;
                m_dsign = dir ? -1 : 1;
                m_A     = -1;
                m_done  = (steps == 0) ? cyc + 1 : cyc + int'(steps) * pe + 1;
            end
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin : compare
        logic          eb, ep, ed;
        logic [W-1:0]  eph;
        logic [CW-1:0] esl;
        if (!rst) begin
            eb = 1'b0; ep = 1'b0; ed = 1'b0; eph = '0; esl = '0;
        end else begin
            eb  = (m_N > 0) && (cyc >= m_T + 1) && (cyc < m_done);
            ep  = (m_N > 0) && (mk(cyc) > mk(cyc - 1));
            ed  = (cyc == m_done);
            eph = code(mpos(cyc));
            esl = CW'(msl(cyc));
        end
        chk("model_busy",       32'(busy),       32'(eb));
        chk("model_step_pulse", 32'(step_pulse), 32'(ep));
        chk("model_done",       32'(done),       32'(ed));
        chk("model_phase",      32'(phase),      32'(eph));
        chk("model_steps_left", 32'(steps_left), 32'(esl));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) tick();
        @(negedge clk);
    endtask

    task automatic issue(input int n, input int p, input logic d, output int t);
        tick();
        steps  = CW'(n);
        period = DW'(p);
        dir    = d;
        start  = 1'b1;
        t      = cyc;
        tick();
        start  = 1'b0;
    endtask

    int fwd_off [8] = '{4, 7, 10, 13, 16, 19, 22, 25};
    logic [W-1:0] fwd_ph [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                 4'b1110, 4'b1100, 4'b1000, 4'b0000};

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int t;
        repeat (3) tick();
        chk("rst_phase", 32'(phase), 'b0000);
        chk("rst_busy",  32'(busy),  0);
        chk("rst_sl",    32'(steps_left), 0);
        rst = 1'b1;
        repeat (2) tick();

        // Forward: 8 steps, period 3; start strobed mid-move must be ignored.
        issue(8, 3, 1'b0, t);
        at_cycle(t + 1);
        chk("fwd_busy_start", 32'(busy), 1);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                at_cycle(t + 24);
                chk("fwd_busy_t24", 32'(busy), 1);
                chk("fwd_done_t24", 32'(done), 0);
            end
            at_cycle(t + fwd_off[i]);
            chk("fwd_pulse", 32'(step_pulse), 1);
            chk("fwd_phase", 32'(phase), 32'(fwd_ph[i]));
            if (i == 2) begin
                steps = 16'd2;
                start = 1'b1;
            end
            if (i == 3) begin
                start = 1'b0;
                steps = 16'd8;
            end
            if (i == 7) begin
                chk("fwd_done", 32'(done), 1);
                chk("fwd_busy_end", 32'(busy), 0);
                chk("fwd_sl_end", 32'(steps_left), 0);
            end
        end
        at_cycle(t + 26);
        chk("fwd_done_after", 32'(done), 0);

        // Reverse 3 steps at period 1, then the same forward back to zero.
        issue(3, 1, 1'b1, t);
        at_cycle(t + 2);
        chk("rev_phase1", 32'(phase), 'b1000);
        at_cycle(t + 3);
        chk("rev_phase2", 32'(phase), 'b1100);
        at_cycle(t + 4);
        chk("rev_phase3", 32'(phase), 'b1110);
        chk("rev_done",   32'(done), 1);
        issue(3, 1, 1'b0, t);
        at_cycle(t + 4);
        chk("ret_phase", 32'(phase), 'b0000);
        chk("ret_done",  32'(done), 1);

        // Abort one cycle after the second step.
        issue(5, 2, 1'b0, t);
        at_cycle(t + 3);
        chk("abt_phase1", 32'(phase), 'b0001);
        at_cycle(t + 5);
        chk("abt_pulse2", 32'(step_pulse), 1);
        at_cycle(t + 6);
        abort = 1'b1;
        at_cycle(t + 7);
        abort = 1'b0;
        chk("abt_done",  32'(done), 1);
        chk("abt_busy",  32'(busy), 0);
        chk("abt_pulse", 32'(step_pulse), 0);
        chk("abt_sl",    32'(steps_left), 3);
        chk("abt_phase", 32'(phase), 'b0011);
        at_cycle(t + 9);
        chk("abt_frozen", 32'(phase), 'b0011);

        // Zero-step command.
        issue(0, 5, 1'b0, t);
        at_cycle(t + 1);
        chk("zero_done", 32'(done), 1);
        chk("zero_busy", 32'(busy), 0);
        chk("zero_sl",   32'(steps_left), 3);
        at_cycle(t + 2);
        chk("zero_done_after", 32'(done), 0);

        // Period 0 acts as 1; reset asserted after two steps.
        issue(4, 0, 1'b0, t);
        at_cycle(t + 2);
        chk("p0_phase1", 32'(phase), 'b0111);
        at_cycle(t + 3);
        chk("p0_phase2", 32'(phase), 'b1111);
        chk("p0_sl",     32'(steps_left), 2);
        #2 rst = 1'b0;
        #1;
        chk("arst_phase", 32'(phase), 0);
        chk("arst_busy",  32'(busy), 0);
        chk("arst_done",  32'(done), 0);
        chk("arst_pulse", 32'(step_pulse), 0);
        chk("arst_sl",    32'(steps_left), 0);
        tick();
        tick();
        chk("arst_hold_phase", 32'(phase), 0);
        chk("arst_hold_busy",  32'(busy), 0);
        rst = 1'b1;
        issue(2, 1, 1'b0, t);
        at_cycle(t + 2);
        chk("post_rst_phase1", 32'(phase), 'b0001);
        at_cycle(t + 3);
        chk("post_rst_phase2", 32'(phase), 'b0011);
        chk("post_rst_done",   32'(done), 1);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
